cby_cfg_param: RTL and testbench

//  Parametrised Y-channel connection block with built-in, double-buffered mux configuration.
//  - Feeds 2*N_IPIN grid input pins (right/left tiles) from W vertical tracks through M-input muxes.
//  - Tracks pass straight through bottom<->top.
//  - Select codes load through a valid/ready command port into shadow registers.
//  - A commit command copies them atomically to the active registers, so routing never glitches mid-load.

---
 rtl/cby_cfg_param.sv | 190 +++++++++++++++++++
 tb/tb_cby_cfg_param.sv | 431 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cby_cfg_param.sv
// ---------------------------------------------------------------------------
// cby_cfg_param
// Y-channel connection block with a double-buffered mux configuration.
//
// Vertical tracks pass straight through (bottom <-> top). Each of the
// 2*N_IPIN grid input pins is driven by an MUX_M-input mux that taps
// MUX_M/2 tracks, taking both the bottom and the top copy of each track.
// Select codes are loaded into shadow registers through a valid/ready
// command port. A commit copies every shadow select into the active
// registers in one edge, so the routing never shows a half-loaded state.
//
// Ports
//   prog_clk          configuration clock, rising edge
//   prog_rst_n        asynchronous active-low reset
//   chany_bottom_in   tracks entering from the bottom
//   chany_top_in      tracks entering from the top
//   chany_bottom_out  copy of chany_top_in
//   chany_top_out     copy of chany_bottom_in
//   grid_right_out    pins g = 0 .. N_IPIN-1
//   grid_left_out     pins g = N_IPIN .. 2*N_IPIN-1
//   cfg_valid/ready   command handshake, accepted when both are high
//   cfg_op            00 write shadow, 01 read shadow, 10 read active, 11 commit
//   cfg_addr          pin index g
//   cfg_wdata         select code for writes
//   cfg_rvalid        one-cycle read response strobe
//   cfg_rdata         read response data
//   cfg_err           sticky error (bad address or bad select code)
//   cfg_configured    high once the first commit has completed
//   commit_count      completed commits, wraps 255 -> 0
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_IDLE   | ready for commands; writes and reads finish here
// ST_COMMIT | one busy cycle; active <= shadow at the end of it
// ---------------------------------------------------------------------------
module cby_cfg_param #(
    parameter int CHAN_W = 20,
    parameter int N_IPIN = 10,
    parameter int MUX_M  = 8,
    parameter int SEL_W  = $clog2(MUX_M),
    parameter int ADDR_W = $clog2(2*N_IPIN)
) (
    input  logic              prog_clk,
    input  logic              prog_rst_n,
    input  logic [CHAN_W-1:0] chany_bottom_in,
    input  logic [CHAN_W-1:0] chany_top_in,
    output logic [CHAN_W-1:0] chany_bottom_out,
    output logic [CHAN_W-1:0] chany_top_out,
    output logic [N_IPIN-1:0] grid_right_out,
    output logic [N_IPIN-1:0] grid_left_out,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [1:0]        cfg_op,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [SEL_W-1:0]  cfg_wdata,
    output logic              cfg_rvalid,
    output logic [SEL_W-1:0]  cfg_rdata,
    output logic              cfg_err,
    output logic              cfg_configured,
    output logic [7:0]        commit_count
);

    localparam int N_PINS = 2*N_IPIN;
    localparam int N_TAPS = MUX_M/2;
    localparam int STRIDE = CHAN_W/N_TAPS;

    localparam logic [1:0] OP_WR     = 2'b00;
    localparam logic [1:0] OP_RD_SH  = 2'b01;
    localparam logic [1:0] OP_RD_ACT = 2'b10;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_COMMIT = 1'b1
    } state_t;

    state_t           r_state;
    logic [SEL_W-1:0] r_shadow [N_PINS];
    logic [SEL_W-1:0] r_active [N_PINS];
    logic             r_ready;
    logic             r_rvalid;
    logic [SEL_W-1:0] r_rdata;
    logic             r_err;
    logic             r_configured;
    logic [7:0]       r_commit_count;

    logic              w_accept;
    logic              w_addr_ok;
    logic              w_wdata_ok;
    logic [N_PINS-1:0] w_pin;

    assign w_accept  = cfg_valid & r_ready;
    assign w_addr_ok = (32'(cfg_addr) < N_PINS);

    // A select code can only be out of range when MUX_M does not fill the
    // whole SEL_W code space.
    generate
        if ((1 << SEL_W) == MUX_M) begin : g_sel_full
            assign w_wdata_ok = 1'b1;
        end else begin : g_sel_partial
            assign w_wdata_ok = (32'(cfg_wdata) < MUX_M);
        end
    endgenerate

    always_ff @(posedge prog_clk or negedge prog_rst_n) begin
        if (!prog_rst_n) begin
            r_state        <= ST_IDLE;
            r_ready        <= 1'b1;
            r_rvalid       <= 1'b0;
            r_rdata        <= '0;
            r_err          <= 1'b0;
            r_configured   <= 1'b0;
            r_commit_count <= '0;
            for (int g = 0; g < N_PINS; g++) begin
                r_shadow[g] <= '0;
                r_active[g] <= '0;
            end
        end else begin
            r_rvalid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        case (cfg_op)
                            OP_WR: begin
                                if (w_addr_ok && w_wdata_ok) begin
                                    r_shadow[cfg_addr] <= cfg_wdata;
                                end else begin
                                    r_err <= 1'b1;
                                end
                            end
                            OP_RD_SH: begin
                                r_rvalid <= 1'b1;
                                r_rdata  <= w_addr_ok ? r_shadow[cfg_addr] : '0;
                                if (!w_addr_ok) begin
                                    r_err <= 1'b1;
                                end
                            end
                            OP_RD_ACT: begin
                                r_rvalid <= 1'b1;
                                r_rdata  <= w_addr_ok ? r_active[cfg_addr] : '0;
                                if (!w_addr_ok) begin
                                    r_err <= 1'b1;
                                end
                            end
                            default: begin
                                r_state <= ST_COMMIT;
                                r_ready <= 1'b0;
                            end
                        endcase
                    end
                end
                default: begin
                    for (int g = 0; g < N_PINS; g++) begin
                        r_active[g] <= r_shadow[g];
                    end
                    r_configured   <= 1'b1;
                    r_commit_count <= r_commit_count + 8'd1;
                    r_state        <= ST_IDLE;
                    r_ready        <= 1'b1;
                end
            endcase
        end
    end

    // Mux input 2t is the bottom copy and 2t+1 the top copy of tap t; taps
    // are spread evenly around the channel starting at the pin's own index.
    generate
        for (genvar g = 0; g < N_PINS; g++) begin : g_pin
            logic [MUX_M-1:0] w_in;
            for (genvar t = 0; t < N_TAPS; t++) begin : g_tap
                localparam int TRK = (g + t*STRIDE) % CHAN_W;
                assign w_in[2*t]   = chany_bottom_in[TRK];
                assign w_in[2*t+1] = chany_top_in[TRK];
            end
            assign w_pin[g] = r_configured & w_in[r_active[g]];
        end
    endgenerate

    assign chany_bottom_out = chany_top_in;
    assign chany_top_out    = chany_bottom_in;
    assign grid_right_out   = w_pin[N_IPIN-1:0];
    assign grid_left_out    = w_pin[N_PINS-1:N_IPIN];

    assign cfg_ready      = r_ready;
    assign cfg_rvalid     = r_rvalid;
    assign cfg_rdata      = r_rdata;
    assign cfg_err        = r_err;
    assign cfg_configured = r_configured;
    assign commit_count   = r_commit_count;

endmodule

// File: tb/tb_cby_cfg_param.sv
module tb_cby_cfg_param;

    localparam int CHAN_W = 20;
    localparam int N_IPIN = 10;
    localparam int MUX_M  = 8;
    localparam int SEL_W  = 3;
    localparam int ADDR_W = 5;
    localparam int N_PINS = 2*N_IPIN;

    logic              prog_clk = 1'b0;
    logic              prog_rst_n = 1'b0;
    logic [CHAN_W-1:0] chany_bottom_in, chany_top_in;
    logic [CHAN_W-1:0] chany_bottom_out, chany_top_out;
    logic [N_IPIN-1:0] grid_right_out, grid_left_out;
    logic              cfg_valid, cfg_ready;
    logic [1:0]        cfg_op;
    logic [ADDR_W-1:0] cfg_addr;
    logic [SEL_W-1:0]  cfg_wdata;
    logic              cfg_rvalid;
    logic [SEL_W-1:0]  cfg_rdata;
    logic              cfg_err, cfg_configured;
    logic [7:0]        commit_count;

    int n_cmp  = 0;
    int n_fail = 0;

    // reference model
    logic [SEL_W-1:0] m_sh  [N_PINS];
    logic [SEL_W-1:0] m_act [N_PINS];
    logic             m_conf;
    logic             m_err;
    logic [7:0]       m_cnt;

    cby_cfg_param dut (
        .prog_clk         (prog_clk),
        .prog_rst_n       (prog_rst_n),
        .chany_bottom_in  (chany_bottom_in),
        .chany_top_in     (chany_top_in),
        .chany_bottom_out (chany_bottom_out),
        .chany_top_out    (chany_top_out),
        .grid_right_out   (grid_right_out),
        .grid_left_out    (grid_left_out),
        .cfg_valid        (cfg_valid),
        .cfg_ready        (cfg_ready),
        .cfg_op           (cfg_op),
        .cfg_addr         (cfg_addr),
        .cfg_wdata        (cfg_wdata),
        .cfg_rvalid       (cfg_rvalid),
        .cfg_rdata        (cfg_rdata),
        .cfg_err          (cfg_err),
        .cfg_configured   (cfg_configured),
        .commit_count     (commit_count)
    );

    always #5 prog_clk = ~prog_clk;

    function automatic void model_reset();
        for (int g = 0; g < N_PINS; g++) begin
            m_sh[g]  = '0;
            m_act[g] = '0;
        end
        m_conf = 1'b0;
        m_err  = 1'b0;
        m_cnt  = 8'd0;
    endfunction

    // Expected {left, right} pins from the model's active selects.
    function automatic logic [N_PINS-1:0] exp_pins();
        logic [N_PINS-1:0] v;
        v = '0;
        for (int g = 0; g < N_PINS; g++) begin
            int tap;
            int trk;
            tap = int'(m_act[g]) / 2;
            trk = (g + tap * (CHAN_W / (MUX_M / 2))) % CHAN_W;
            if (m_conf)
                v[g] = (int'(m_act[g]) % 2 == 1) ? chany_top_in[trk] : chany_bottom_in[trk];
        end
        return v;
    endfunction

    task automatic randomize_tracks();
        chany_bottom_in = CHAN_W'($urandom);
        chany_top_in    = CHAN_W'($urandom);
        #1;
    endtask

    // Drive one command from a negedge and return 1 time unit after the
    // edge that accepted it; the model is updated for non-commit ops.
    task automatic cmd(input logic [1:0] op, input logic [ADDR_W-1:0] addr,
                       input logic [SEL_W-1:0] wd);
        int n;
        @(negedge prog_clk);
        cfg_valid = 1'b1;
        cfg_op    = op;
        cfg_addr  = addr;
        cfg_wdata = wd;
        n = 0;
        while (cfg_ready !== 1'b1 && n < 8) begin
            @(negedge prog_clk);
            n++;
        end
        n_cmp++;
        if (n == 8) begin
            n_fail++;
            $display("FAIL cmd_accept_timeout ready=%b required 1", cfg_ready);
        end
        @(posedge prog_clk);
        #1;
        cfg_valid = 1'b0;
        case (op)
            2'b00: if (int'(addr) < N_PINS) m_sh[addr] = wd; else m_err = 1'b1;
            2'b01, 2'b10: if (int'(addr) >= N_PINS) m_err = 1'b1;
            default: ;
        endcase
    endtask

    task automatic do_commit();
        cmd(2'b11, ADDR_W'($urandom), SEL_W'($urandom));
        @(posedge prog_clk);
        #1;
        for (int g = 0; g < N_PINS; g++) m_act[g] = m_sh[g];
        m_conf = 1'b1;
        m_cnt  = m_cnt + 8'd1;
    endtask

    task automatic test_reset();
        prog_rst_n = 1'b0;
        model_reset();
        randomize_tracks();
        repeat (2) @(posedge prog_clk);
        @(negedge prog_clk);
        prog_rst_n = 1'b1;
        @(posedge prog_clk);
        #1;
        randomize_tracks();
        n_cmp++;
        if ({grid_left_out, grid_right_out} !== '0) begin
            n_fail++;
            $display("FAIL reset_grid got=%h want=0", {grid_left_out, grid_right_out});
        end
        n_cmp++;
        if (cfg_ready !== 1'b1 || cfg_rvalid !== 1'b0 || cfg_err !== 1'b0 || cfg_configured !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl got ready=%b rvalid=%b err=%b conf=%b want 1 0 0 0",
                     cfg_ready, cfg_rvalid, cfg_err, cfg_configured);
        end
        n_cmp++;
        if (commit_count !== 8'd0 || cfg_rdata !== '0) begin
            n_fail++;
            $display("FAIL reset_count got cnt=%0d rdata=%0d want 0 0", commit_count, cfg_rdata);
        end
        n_cmp++;
        if (chany_bottom_out !== chany_top_in || chany_top_out !== chany_bottom_in) begin
            n_fail++;
            $display("FAIL passthrough got bo=%h to=%h want %h %h",
                     chany_bottom_out, chany_top_out, chany_top_in, chany_bottom_in);
        end
    endtask

    task automatic test_route();
        cmd(2'b00, 5'd0, 3'd2);
        cmd(2'b11, 5'd0, 3'd0);
        n_cmp++;
        if (cfg_configured !== 1'b0 || {grid_left_out, grid_right_out} !== '0) begin
            n_fail++;
            $display("FAIL commit_early got conf=%b grid=%h want 0 0",
                     cfg_configured, {grid_left_out, grid_right_out});
        end
        @(posedge prog_clk);
        #1;
        for (int g = 0; g < N_PINS; g++) m_act[g] = m_sh[g];
        m_conf = 1'b1;
        m_cnt  = m_cnt + 8'd1;
        n_cmp++;
        if (grid_right_out[0] !== chany_bottom_in[5]) begin
            n_fail++;
            $display("FAIL route_g0 got=%b want=%b", grid_right_out[0], chany_bottom_in[5]);
        end
        chany_bottom_in[5] = ~chany_bottom_in[5];
        #1;
        n_cmp++;
        if (grid_right_out[0] !== chany_bottom_in[5]) begin
            n_fail++;
            $display("FAIL route_toggle got=%b want=%b", grid_right_out[0], chany_bottom_in[5]);
        end
        n_cmp++;
        if ({grid_left_out, grid_right_out} !== exp_pins() || commit_count !== m_cnt) begin
            n_fail++;
            $display("FAIL route_all got=%h cnt=%0d want=%h cnt=%0d",
                     {grid_left_out, grid_right_out}, commit_count, exp_pins(), m_cnt);
        end
    endtask

    task automatic test_shadow_isolation();
        cmd(2'b00, 5'd0, 3'd7);
        randomize_tracks();
        n_cmp++;
        if (grid_right_out[0] !== chany_bottom_in[5]) begin
            n_fail++;
            $display("FAIL shadow_leak got=%b want=%b", grid_right_out[0], chany_bottom_in[5]);
        end
        cmd(2'b01, 5'd0, 3'd0);
        n_cmp++;
        if (cfg_rvalid !== 1'b1 || cfg_rdata !== 3'd7) begin
            n_fail++;
            $display("FAIL read_shadow got rv=%b d=%0d want 1 7", cfg_rvalid, cfg_rdata);
        end
        cmd(2'b10, 5'd0, 3'd0);
        n_cmp++;
        if (cfg_rvalid !== 1'b1 || cfg_rdata !== 3'd2) begin
            n_fail++;
            $display("FAIL read_active got rv=%b d=%0d want 1 2", cfg_rvalid, cfg_rdata);
        end
        do_commit();
        n_cmp++;
        if (grid_right_out[0] !== chany_top_in[15]) begin
            n_fail++;
            $display("FAIL route_top15 got=%b want=%b", grid_right_out[0], chany_top_in[15]);
        end
    endtask

    task automatic test_commit_busy();
        @(negedge prog_clk);
        cfg_valid = 1'b1;
        cfg_op    = 2'b11;
        n_cmp++;
        if (cfg_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_pre got ready=%b want 1", cfg_ready);
        end
        @(posedge prog_clk);
        #1;
        cfg_op   = 2'b10;
        cfg_addr = 5'd0;
        @(negedge prog_clk);
        n_cmp++;
        if (cfg_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_ready got ready=%b want 0", cfg_ready);
        end
        @(posedge prog_clk);
        #1;
        for (int g = 0; g < N_PINS; g++) m_act[g] = m_sh[g];
        m_cnt = m_cnt + 8'd1;
        n_cmp++;
        if (cfg_rvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_ignored got rvalid=%b want 0", cfg_rvalid);
        end
        @(negedge prog_clk);
        n_cmp++;
        if (cfg_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_post got ready=%b want 1", cfg_ready);
        end
        @(posedge prog_clk);
        #1;
        cfg_valid = 1'b0;
        n_cmp++;
        if (cfg_rvalid !== 1'b1 || cfg_rdata !== m_act[0] || commit_count !== m_cnt) begin
            n_fail++;
            $display("FAIL busy_follow got rv=%b d=%0d cnt=%0d want 1 %0d %0d",
                     cfg_rvalid, cfg_rdata, commit_count, m_act[0], m_cnt);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 6; i++) begin
            logic [ADDR_W-1:0] a;
            logic [SEL_W-1:0]  d;
            a = ADDR_W'($urandom_range(N_PINS - 1));
            d = SEL_W'($urandom);
            cmd(2'b00, a, d);
            cmd(2'b01, a, 3'd0);
            n_cmp++;
            if (cfg_rvalid !== 1'b1 || cfg_rdata !== d) begin
                n_fail++;
                $display("FAIL b2b_read a=%0d got rv=%b d=%0d want 1 %0d", a, cfg_rvalid, cfg_rdata, d);
            end
        end
        @(posedge prog_clk);
        #1;
        n_cmp++;
        if (cfg_rvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL rvalid_pulse got=%b want 0", cfg_rvalid);
        end
    endtask

    task automatic test_errors();
        n_cmp++;
        if (cfg_err !== 1'b0) begin
            n_fail++;
            $display("FAIL err_pre got=%b want 0", cfg_err);
        end
        cmd(2'b00, 5'd20, 3'd5);
        n_cmp++;
        if (cfg_err !== 1'b1) begin
            n_fail++;
            $display("FAIL err_write got=%b want 1", cfg_err);
        end
        for (int g = 0; g < N_PINS; g++) begin
            cmd(2'b01, ADDR_W'(g), 3'd0);
            n_cmp++;
            if (cfg_rdata !== m_sh[g]) begin
                n_fail++;
                $display("FAIL err_noshadow g=%0d got=%0d want=%0d", g, cfg_rdata, m_sh[g]);
            end
        end
        cmd(2'b01, 5'd25, 3'd0);
        n_cmp++;
        if (cfg_rvalid !== 1'b1 || cfg_rdata !== 3'd0 || cfg_err !== 1'b1) begin
            n_fail++;
            $display("FAIL err_read got rv=%b d=%0d err=%b want 1 0 1", cfg_rvalid, cfg_rdata, cfg_err);
        end
        cmd(2'b10, 5'd31, 3'd0);
        n_cmp++;
        if (cfg_rvalid !== 1'b1 || cfg_rdata !== 3'd0) begin
            n_fail++;
            $display("FAIL err_read_act got rv=%b d=%0d want 1 0", cfg_rvalid, cfg_rdata);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 200; i++) begin
            logic [1:0]        op;
            logic [ADDR_W-1:0] a;
            logic [SEL_W-1:0]  d;
            logic [SEL_W-1:0]  exp_rd;
            op = 2'($urandom);
            a  = ($urandom_range(9) == 0) ? ADDR_W'($urandom_range(31, N_PINS))
                                          : ADDR_W'($urandom_range(N_PINS - 1));
            d  = SEL_W'($urandom);
            randomize_tracks();
            exp_rd = '0;
            if (int'(a) < N_PINS) exp_rd = (op == 2'b01) ? m_sh[a] : m_act[a];
            if (op == 2'b11) do_commit();
            else cmd(op, a, d);
            n_cmp++;
            if (op == 2'b01 || op == 2'b10) begin
                if (cfg_rvalid !== 1'b1 || cfg_rdata !== exp_rd) begin
                    n_fail++;
                    $display("FAIL rnd_read i=%0d op=%0d a=%0d got rv=%b d=%0d want 1 %0d",
                             i, op, a, cfg_rvalid, cfg_rdata, exp_rd);
                end
            end else if (cfg_rvalid !== 1'b0) begin
                n_fail++;
                $display("FAIL rnd_rvalid i=%0d got=%b want 0", i, cfg_rvalid);
            end
            randomize_tracks();
            n_cmp++;
            if ({grid_left_out, grid_right_out} !== exp_pins() || cfg_err !== m_err ||
                cfg_configured !== m_conf || commit_count !== m_cnt) begin
                n_fail++;
                $display("FAIL rnd_state i=%0d got grid=%h err=%b conf=%b cnt=%0d want %h %b %b %0d",
                         i, {grid_left_out, grid_right_out}, cfg_err, cfg_configured, commit_count,
                         exp_pins(), m_err, m_conf, m_cnt);
            end
        end
    endtask

    task automatic test_count_wrap();
        for (int i = 0; i < 256 && m_cnt != 8'd255; i++) do_commit();
        n_cmp++;
        if (commit_count !== m_cnt) begin
            n_fail++;
            $display("FAIL count_255 got=%0d want=%0d", commit_count, m_cnt);
        end
        do_commit();
        n_cmp++;
        if (commit_count !== 8'd0 || m_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL count_wrap got=%0d want 0", commit_count);
        end
    endtask

    task automatic test_reset_mid_commit();
        cmd(2'b00, 5'd7, 3'd5);
        cmd(2'b11, 5'd0, 3'd0);
        prog_rst_n = 1'b0;
        #1;
        model_reset();
        randomize_tracks();
        n_cmp++;
        if ({grid_left_out, grid_right_out} !== '0 || cfg_configured !== 1'b0 ||
            commit_count !== 8'd0 || cfg_ready !== 1'b1 || cfg_err !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_async got grid=%h conf=%b cnt=%0d ready=%b err=%b want 0 0 0 1 0",
                     {grid_left_out, grid_right_out}, cfg_configured, commit_count, cfg_ready, cfg_err);
        end
        @(negedge prog_clk);
        prog_rst_n = 1'b1;
        repeat (2) @(posedge prog_clk);
        #1;
        n_cmp++;
        if ({grid_left_out, grid_right_out} !== '0 || cfg_configured !== 1'b0 || commit_count !== 8'd0) begin
            n_fail++;
            $display("FAIL midrst_abort got grid=%h conf=%b cnt=%0d want 0 0 0",
                     {grid_left_out, grid_right_out}, cfg_configured, commit_count);
        end
        cmd(2'b10, 5'd7, 3'd0);
        n_cmp++;
        if (cfg_rvalid !== 1'b1 || cfg_rdata !== 3'd0) begin
            n_fail++;
            $display("FAIL midrst_active got rv=%b d=%0d want 1 0", cfg_rvalid, cfg_rdata);
        end
    endtask

    initial begin
        cfg_valid       = 1'b0;
        cfg_op          = 2'b00;
        cfg_addr        = '0;
        cfg_wdata       = '0;
        chany_bottom_in = '0;
        chany_top_in    = '0;
        model_reset();
        test_reset();
        test_route();
        test_shadow_isolation();
        test_commit_busy();
        test_back_to_back();
        test_errors();
        test_random();
        test_count_wrap();
        test_reset_mid_commit();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
